int_ctrl: RTL and testbench

- Multi-source interrupt controller for the pP core.
- Captures rising edges on NSRC external interrupt lines, holds them as pending bits, and gates them through a software-written mask.
- Selects one source by fixed priority, drives the active-low int_req consumed by the interrupt register, and presents the winning vector.
- Sequences one request per service: assert, wait for int_ack, clear pending, wait for service end.

---
 rtl/pp_pkg.sv | 16 +
 rtl/int_ctrl_if.sv | 29 ++
 rtl/int_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 92 +++++++++
 tb/tb_int_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pp_pkg.sv
// Shared pP-core definitions: instruction kind codes and interrupt FSM states.
// No logic; constants and types only.
// No flow control.
package pp_pkg;

  localparam logic [3:0] KIND_RETI = 4'b1000;
  localparam logic [3:0] KIND_ENAI = 4'b1001;
  localparam logic [3:0] KIND_DISI = 4'b1010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } ic_state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// Bus between the interrupt controller and its surroundings (sources, mask port, interrupt register).
// Pure wiring, no latency.
// int_req/int_ack form the request/acknowledge handshake; no other backpressure.
interface int_ctrl_if #(
  parameter int NSRC = 4,
  parameter int VW   = 2
);
  logic [NSRC-1:0] src;
  logic            mask_we;
  logic [NSRC-1:0] mask_wd;
  logic            int_ack;
  logic            int_req;
  logic [VW-1:0]   int_vec;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic            busy;

  // Environment side: drives lines, mask writes and the acknowledge.
  modport master (
    output src, mask_wd, mask_we, int_ack,
    input  int_req, int_vec, pend, mask, busy
  );

  // Controller side.
  modport slave (
    input  src, mask_wd, mask_we, int_ack,
    output int_req, int_vec, pend, mask, busy
  );
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set bit of elig wins.
// Purely combinational, zero latency.
// No flow control.
module int_prio_enc #(
  parameter int NSRC = 4,
  parameter int VW   = 2
) (
  input  logic [NSRC-1:0] elig,
  output logic [VW-1:0]   win,
  output logic            any
);

  // Scan from the top down so the lowest index is the last one to overwrite win.
  always_comb begin
    win = '0;
    any = |elig;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) win = VW'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Multi-source interrupt controller: edge capture, mask, fixed priority, one request per service.
// Pending bit set at edge t -> int_req low at edge t+1 at the earliest (qualified by ck2==0).
// A committed request holds until int_ack; no new request until the service returns.
module int_ctrl
  import pp_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int VW   = 2
) (
  input  logic        ck,
  input  logic        res,
  input  logic        ck2,
  int_ctrl_if.slave   bus
);

  logic [NSRC-1:0] src_d;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [VW-1:0]   win;
  logic            any;
  logic [VW-1:0]   vec_q, vec_d;
  ic_state_t       state_q, state_d;

  assign rise = bus.src & ~src_d;
  assign elig = pend_q & mask_q;

  int_prio_enc #(.NSRC(NSRC), .VW(VW)) u_prio (
    .elig (elig),
    .win  (win),
    .any  (any)
  );

  // Edge history, pending bits (a same-cycle rise beats the service clear) and mask register.
  always_ff @(posedge ck) begin
    src_d <= bus.src;
    if (res) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | rise;
      if (bus.mask_we) mask_q <= bus.mask_wd;
    end
  end

  // Request sequencer state and latched vector.
  always_ff @(posedge ck) begin
    if (res) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // Next state: vector is latched on entry to ASSERT and frozen until the next request.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    clr     = '0;
    if (!ck2) begin
      case (state_q)
        IDLE: begin
          if (any) begin
            vec_d   = win;
            state_d = ASSERT;
          end
        end
        ASSERT: begin
          if (bus.int_ack) begin
            clr     = NSRC'(1) << vec_q;
            state_d = SERVICE;
          end
        end
        SERVICE: begin
          if (!bus.int_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.int_req = (state_q != ASSERT);
  assign bus.int_vec = vec_q;
  assign bus.pend    = pend_q;
  assign bus.mask    = mask_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic ck  = 1'b0;
  logic res = 1'b1;
  logic ck2 = 1'b0;

  int_ctrl_if #(.NSRC(4), .VW(2)) bus ();

  int_ctrl #(.NSRC(4), .VW(2)) dut (
    .ck  (ck),
    .res (res),
    .ck2 (ck2),
    .bus (bus)
  );

  always #5 ck = ~ck;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic [3:0] src;
    logic       mwe;
    logic [3:0] mwd;
    logic       c2;
    logic       ack;
    logic       req;
    logic [1:0] vec;
    logic [3:0] pend;
    logic [3:0] mask;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] s, input logic we, input logic [3:0] wd,
                              input logic c2, input logic ack, input logic req,
                              input logic [1:0] vec, input logic [3:0] pend,
                              input logic [3:0] mask, input logic busy);
    vec_t v;
    v.src = s; v.mwe = we; v.mwd = wd; v.c2 = c2; v.ack = ack;
    v.req = req; v.vec = vec; v.pend = pend; v.mask = mask; v.busy = busy;
    return v;
  endfunction

  // Behavioural reference: pending set, mask, and a service phase.
  logic [3:0] m_pend, m_mask, m_src_d;
  logic [1:0] m_vec;
  int         m_phase;   // 0 = waiting for work, 1 = request outstanding, 2 = being serviced

  task automatic model_reset(input logic [3:0] s);
    m_pend = 4'b0; m_mask = 4'b0; m_src_d = s; m_vec = 2'd0; m_phase = 0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] s, input logic we,
                            input logic [3:0] wd, input logic c2, input logic ack);
    logic [3:0] eligible, newly, cleared;
    int first;
    if (r) begin
      model_reset(s);
      return;
    end
    eligible = m_pend & m_mask;
    newly    = s & ~m_src_d;
    cleared  = 4'b0;
    first    = -1;
    for (int i = 0; i < 4; i++) if (eligible[i] && first < 0) first = i;
    if (!c2) begin
      if (m_phase == 0 && first >= 0) begin
        m_vec = 2'(first); m_phase = 1;
      end else if (m_phase == 1 && ack) begin
        cleared[m_vec] = 1'b1; m_phase = 2;
      end else if (m_phase == 2 && !ack) begin
        m_phase = 0;
      end
    end
    m_pend  = (m_pend & ~cleared) | newly;
    if (we) m_mask = wd;
    m_src_d = s;
  endtask

  task automatic step(input logic [3:0] s, input logic we, input logic [3:0] wd,
                      input logic c2, input logic ack);
    bus.src = s; bus.mask_we = we; bus.mask_wd = wd; ck2 = c2; bus.int_ack = ack;
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string name, input logic req, input logic [1:0] vec,
                     input logic [3:0] pend, input logic [3:0] mask, input logic busy);
    nchk++;
    if (bus.int_req !== req || bus.int_vec !== vec || bus.pend !== pend ||
        bus.mask !== mask || bus.busy !== busy) begin
      nerr++;
      $display("FAIL %s: got req=%b vec=%0d pend=%b mask=%b busy=%b, want req=%b vec=%0d pend=%b mask=%b busy=%b",
               name, bus.int_req, bus.int_vec, bus.pend, bus.mask, bus.busy,
               req, vec, pend, mask, busy);
    end
  endtask

  initial begin
    logic [3:0] rs;
    logic       rwe, rc2, rack, rres;
    logic [3:0] rwd;

    // Reset with a line already high.
    res = 1'b1;
    step(4'b0010, 1'b0, 4'h0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("reset", 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
    res = 1'b0;

    //                src      we    wd       ck2   ack   req   vec   pend     mask     busy
    tbl.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0100, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1010, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1010, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b1000, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1000, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b1000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1000, 4'b1111, 1'b1));
    tbl.push_back(mk(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b1001, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0001, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 4'b1111, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b1111, 1'b1));

    foreach (tbl[i]) begin
      step(tbl[i].src, tbl[i].mwe, tbl[i].mwd, tbl[i].c2, tbl[i].ack);
      chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].vec, tbl[i].pend, tbl[i].mask, tbl[i].busy);
    end

    // ck2 gating in ASSERT and SERVICE.
    step(4'b0000, 1'b0, 4'h0, 1'b1, 1'b1); chk("hold_assert",   1'b0, 2'd0, 4'b0001, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1); chk("ack_q",         1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0); chk("hold_svc1",     1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0); chk("hold_svc2",     1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0); chk("svc_return",    1'b1, 2'd0, 4'b0000, 4'b1111, 1'b0);
    // Rise on the same cycle as the clear: set wins, re-requested after return.
    step(4'b0010, 1'b0, 4'h0, 1'b0, 1'b0); chk("pend1",         1'b1, 2'd0, 4'b0010, 4'b1111, 1'b0);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0); chk("req1",          1'b0, 2'd1, 4'b0010, 4'b1111, 1'b1);
    step(4'b0010, 1'b0, 4'h0, 1'b0, 1'b1); chk("set_wins",      1'b1, 2'd1, 4'b0010, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0); chk("ret1",          1'b1, 2'd1, 4'b0010, 4'b1111, 1'b0);
    // Acknowledge already high when the request is raised.
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1); chk("req1_again",    1'b0, 2'd1, 4'b0010, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1); chk("early_ack",     1'b1, 2'd1, 4'b0000, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0); chk("ret1b",         1'b1, 2'd1, 4'b0000, 4'b1111, 1'b0);
    // Edge capture runs while ck2 is high; the FSM waits.
    step(4'b0100, 1'b0, 4'h0, 1'b1, 1'b0); chk("cap_ck2hi",     1'b1, 2'd1, 4'b0100, 4'b1111, 1'b0);
    step(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0); chk("idle_ck2hi",    1'b1, 2'd1, 4'b0100, 4'b1111, 1'b0);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0); chk("req2",          1'b0, 2'd2, 4'b0100, 4'b1111, 1'b1);
    step(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1); chk("svc2",          1'b1, 2'd2, 4'b0000, 4'b1111, 1'b1);
    // Reset mid-service with a line high: nothing pends afterwards.
    res = 1'b1;
    step(4'b0001, 1'b0, 4'h0, 1'b0, 1'b1); chk("reset_midsvc",  1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
    res = 1'b0;
    model_reset(4'b0001);
    step(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0); chk("post_reset",    1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
    model_edge(1'b0, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    rs = 4'b0001;
    for (int n = 0; n < 2000; n++) begin
      rs   = rs ^ (4'($urandom) & 4'($urandom));
      rwe  = ($urandom_range(0, 9) == 0);
      rwd  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      rc2  = ($urandom_range(0, 9) < 3);
      rack = ($urandom_range(0, 2) == 0);
      rres = ($urandom_range(0, 199) == 0);
      model_edge(rres, rs, rwe, rwd, rc2, rack);
      res = rres;
      step(rs, rwe, rwd, rc2, rack);
      chk($sformatf("rand%0d", n), (m_phase != 1), m_vec, m_pend, m_mask, (m_phase != 0));
    end
    res = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
